ram_fifo_ctrl: RTL

FIFO controller that sits directly upstream of the single-port `ram_single` storage (7-bit address, 8-bit data, write on `we` at the clock edge, registered read data on `q`). It turns a valid/ready producer stream and a valid/ready consumer stream into the RAM's `a`/`d`/`we` accesses. It also arbitrates the RAM's single port between writes and reads. A one-word output register decouples the RAM read latency from the consumer.

---
 rtl/ram_fifo_ctrl_pkg.sv | 18 +
 rtl/ram_fifo_ptr.sv | 33 +++
 rtl/ram_fifo_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// ram_fifo_ctrl_pkg : shared constants and FSM state type for the RAM FIFO
// Revision: 1.0
// =============================================================================
package ram_fifo_ctrl_pkg;

    localparam int RAM_FIFO_DATA_W = 8;
    localparam int RAM_FIFO_ADDR_W = 7;
    localparam int RAM_FIFO_DEPTH  = 2 ** RAM_FIFO_ADDR_W;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } fifo_state_e;

endpackage : ram_fifo_ctrl_pkg
`default_nettype wire

// File: rtl/ram_fifo_ptr.sv
`default_nettype none
// =============================================================================
// ram_fifo_ptr : wrapping RAM address pointer with increment enable
// Revision: 1.0
// =============================================================================
module ram_fifo_ptr
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_ptr;

    // Natural binary wrap keeps the pointer inside the power-of-two RAM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + C_PTR_ONE;
        end
    end

    assign ptr = r_ptr;

endmodule : ram_fifo_ptr
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// =============================================================================
// ram_fifo_ctrl : valid/ready FIFO controller over a single-port registered RAM
// Optional RAM_FIFO_BYPASS_EN: a write into an empty FIFO loads the output
// register directly. Revision: 1.0
// =============================================================================
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = RAM_FIFO_DATA_W,
    parameter int ADDR_W = RAM_FIFO_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] C_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    fifo_state_e       r_state;
    fifo_state_e       w_state_nxt;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic [ADDR_W:0]   r_ram_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_reg;

    logic              w_rd_issue;
    logic              w_full;
    logic              w_wr_ready;
    logic              w_wr_acc;
    logic              w_pop;
    logic              w_bypass;
    logic              w_ram_wr;
    logic              w_in_flight;
    logic [ADDR_W:0]   w_count;
    logic [ADDR_W-1:0] w_ram_a;
    logic [DATA_W-1:0] w_ram_d;
    logic              w_ram_we;

    // Read issue depends only on registers so rd_ready never reaches the RAM port.
    assign w_rd_issue  = (r_state == IDLE) && (r_ram_cnt != '0) && !r_out_valid;
    assign w_full      = (r_ram_cnt == C_FULL_CNT);
    assign w_wr_ready  = !w_full && !w_rd_issue;
    assign w_wr_acc    = wr_valid && w_wr_ready;
    assign w_pop       = r_out_valid && rd_ready;
    assign w_in_flight = (r_state == RD_WAIT);
    assign w_count     = r_ram_cnt
                       + {{ADDR_W{1'b0}}, w_in_flight}
                       + {{ADDR_W{1'b0}}, r_out_valid};

`ifdef RAM_FIFO_BYPASS_EN
    assign w_bypass = w_wr_acc && (w_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_ram_wr = w_wr_acc && !w_bypass;

    ram_fifo_ptr #(
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_ram_wr),
        .ptr     (w_wr_ptr)
    );

    ram_fifo_ptr #(
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_rd_issue),
        .ptr     (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ram_a     = w_rd_ptr;
        w_ram_d     = '0;
        w_ram_we    = 1'b0;
        case (r_state)
            IDLE:    if (w_rd_issue) w_state_nxt = RD_WAIT;
            RD_WAIT: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Writes never coincide with an issue cycle, so the port is free here.
        if (w_ram_wr) begin
            w_ram_a  = w_wr_ptr;
            w_ram_d  = wr_data;
            w_ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ram_cnt <= '0;
        end else if (w_ram_wr) begin
            r_ram_cnt <= r_ram_cnt + C_CNT_ONE;
        end else if (w_rd_issue) begin
            r_ram_cnt <= r_ram_cnt - C_CNT_ONE;
        end
    end

    // The RAM read completes in RD_WAIT; a discarded read simply never loads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_reg   <= '0;
        end else if (r_state == RD_WAIT) begin
            r_out_valid <= 1'b1;
            r_out_reg   <= ram_q;
        end else if (w_bypass) begin
            r_out_valid <= 1'b1;
            r_out_reg   <= wr_data;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    // Outputs show the cleared values for the whole time reset_n is low.
    assign wr_ready = !reset_n || w_wr_ready;
    assign rd_valid = reset_n && r_out_valid;
    assign rd_data  = reset_n ? r_out_reg : '0;
    assign count    = reset_n ? w_count : '0;
    assign full     = reset_n && w_full;
    assign empty    = !reset_n || (w_count == '0);
    assign ram_a    = reset_n ? w_ram_a : '0;
    assign ram_d    = reset_n ? w_ram_d : '0;
    assign ram_we   = reset_n && w_ram_we;

endmodule : ram_fifo_ctrl
`default_nettype wire
